atomrvcore_ctrl_fsm: RTL and testbench

Multi-cycle control sequencer for the atomRVCORE single-issue RV32I core. It fetches each instruction over an instruction-memory handshake, holds it in an instruction register, and classifies the opcode into the one-hot format enables (R/I/S/SB/U/UJ) that drive the instruction decode unit. It then steps the instruction through EXEC, MEM and WB, issuing data-memory read/write enables, register write-back and PC update controls.

---
 rtl/atomrvcore_ctrl_fsm.sv | 159 +++++++++++++++
 tb/tb_atomrvcore_ctrl_fsm.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/atomrvcore_ctrl_fsm.sv
// atomRVCORE multi-cycle control sequencer: fetch, classify, and step each
// RV32I instruction through EXEC/MEM/WB with memory and PC controls.
module atomrvcore_ctrl_fsm #(
    parameter int DATAWIDTH = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    output logic                 imem_req_o,
    input  logic                 imem_valid_i,
    input  logic [DATAWIDTH-1:0] imem_rdata_i,
    output logic [DATAWIDTH-1:0] instr_o,
    output logic                 R_EN_o,
    output logic                 I_EN_o,
    output logic                 S_EN_o,
    output logic                 SB_EN_o,
    output logic                 U_EN_o,
    output logic                 UJ_EN_o,
    output logic                 DR_EN_o,
    output logic                 DWR_EN_o,
    input  logic                 dmem_ack_i,
    input  logic                 branch_taken_i,
    output logic                 reg_we_o,
    output logic                 pc_we_o,
    output logic [1:0]           pc_sel_o,
    output logic                 illegal_o,
    output logic [2:0]           state_o
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4
    } state_t;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    state_t               state, state_n;
    logic [DATAWIDTH-1:0] instr;
    // Format enables in order {R, I, S, SB, U, UJ}.
    logic [5:0]           fmt, fmt_n, cls;
    logic                 req;
    logic                 is_load, is_jalr, rd_zero;

    assign is_load = (instr[6:0] == OP_LOAD);
    assign is_jalr = (instr[6:0] == OP_JALR);
    assign rd_zero = (instr[11:7] == 5'd0);

    always_comb begin
        cls = 6'b000000;
        case (instr[6:0])
            OP_R:                      cls = 6'b100000;
            OP_IMM, OP_LOAD, OP_JALR:  cls = 6'b010000;
            OP_STORE:                  cls = 6'b001000;
            OP_BR:                     cls = 6'b000100;
            OP_LUI, OP_AUIPC:          cls = 6'b000010;
            OP_JAL:                    cls = 6'b000001;
            default:                   cls = 6'b000000;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= FETCH;
            instr <= DATAWIDTH'(32'h0000_0013);
            fmt   <= 6'b000000;
        end else begin
            state <= state_n;
            fmt   <= fmt_n;
            if (state == FETCH && imem_valid_i)
                instr <= imem_rdata_i;
        end
    end

    always_comb begin
        state_n   = state;
        fmt_n     = fmt;
        req       = 1'b0;
        DR_EN_o   = 1'b0;
        DWR_EN_o  = 1'b0;
        reg_we_o  = 1'b0;
        pc_we_o   = 1'b0;
        pc_sel_o  = 2'b00;
        illegal_o = 1'b0;
        case (state)
            FETCH: begin
                req   = 1'b1;
                fmt_n = 6'b000000;
                if (imem_valid_i)
                    state_n = DECODE;
            end
            DECODE: begin
                if (cls != 6'b000000) begin
                    fmt_n   = cls;
                    state_n = EXEC;
                end else begin
                    illegal_o = 1'b1;
                    pc_we_o   = 1'b1;
                    state_n   = FETCH;
                end
            end
            EXEC: begin
                if (is_load || fmt[3]) begin
                    state_n = MEM;
                end else if (fmt[2]) begin
                    pc_we_o  = 1'b1;
                    pc_sel_o = branch_taken_i ? 2'b01 : 2'b00;
                    fmt_n    = 6'b000000;
                    state_n  = FETCH;
                end else begin
                    state_n = WB;
                end
            end
            MEM: begin
                DR_EN_o  = is_load;
                DWR_EN_o = ~is_load;
                if (dmem_ack_i) begin
                    if (is_load) begin
                        state_n = WB;
                    end else begin
                        // Stores retire straight from MEM on the ack cycle.
                        pc_we_o = 1'b1;
                        fmt_n   = 6'b000000;
                        state_n = FETCH;
                    end
                end
            end
            WB: begin
                reg_we_o = ~rd_zero;
                pc_we_o  = 1'b1;
                if (fmt[0])
                    pc_sel_o = 2'b01;
                else if (is_jalr)
                    pc_sel_o = 2'b10;
                fmt_n   = 6'b000000;
                state_n = FETCH;
            end
            default: begin
                fmt_n   = 6'b000000;
                state_n = FETCH;
            end
        endcase
    end

    assign imem_req_o = req & ~rst_i;
    assign instr_o    = instr;
    assign state_o    = state;
    assign {R_EN_o, I_EN_o, S_EN_o, SB_EN_o, U_EN_o, UJ_EN_o} = fmt;

endmodule

// File: tb/tb_atomrvcore_ctrl_fsm.sv
// Scoreboard bench for atomrvcore_ctrl_fsm: the driver queues per-instruction
// expectations, the monitor retires them on each pc_we_o strobe.
module tb_atomrvcore_ctrl_fsm;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        imem_req_o;
    logic        imem_valid_i;
    logic [31:0] imem_rdata_i;
    logic [31:0] instr_o;
    logic        R_EN_o, I_EN_o, S_EN_o, SB_EN_o, U_EN_o, UJ_EN_o;
    logic        DR_EN_o, DWR_EN_o;
    logic        dmem_ack_i;
    logic        branch_taken_i;
    logic        reg_we_o, pc_we_o;
    logic [1:0]  pc_sel_o;
    logic        illegal_o;
    logic [2:0]  state_o;

    atomrvcore_ctrl_fsm #(.DATAWIDTH(32)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .imem_req_o(imem_req_o), .imem_valid_i(imem_valid_i),
        .imem_rdata_i(imem_rdata_i), .instr_o(instr_o),
        .R_EN_o(R_EN_o), .I_EN_o(I_EN_o), .S_EN_o(S_EN_o),
        .SB_EN_o(SB_EN_o), .U_EN_o(U_EN_o), .UJ_EN_o(UJ_EN_o),
        .DR_EN_o(DR_EN_o), .DWR_EN_o(DWR_EN_o), .dmem_ack_i(dmem_ack_i),
        .branch_taken_i(branch_taken_i), .reg_we_o(reg_we_o),
        .pc_we_o(pc_we_o), .pc_sel_o(pc_sel_o), .illegal_o(illegal_o),
        .state_o(state_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [5:0] fmt;
        int         rwe;
        logic [1:0] sel;
        int         ill;
        int         dr;
        int         dwr;
        int         cyc;
        logic       wb;
        logic [2:0] end_st;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d required %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor accumulators for the instruction in flight.
    int         m_cyc, m_rwe, m_ill, m_dr, m_dwr, m_inv;
    logic [5:0] m_fmt, fmt_v;
    logic       m_wb;
    logic [16:0] outs;
    exp_t       e;

    task automatic clear_acc();
        m_cyc = 0; m_rwe = 0; m_ill = 0; m_dr = 0; m_dwr = 0; m_inv = 0;
        m_fmt = '0; m_wb = 1'b0;
    endtask

    always @(negedge clk_i) begin
        fmt_v = {R_EN_o, I_EN_o, S_EN_o, SB_EN_o, U_EN_o, UJ_EN_o};
        if (rst_i) begin
            outs = {imem_req_o, fmt_v, DR_EN_o, DWR_EN_o, reg_we_o, pc_we_o,
                    pc_sel_o, illegal_o, state_o};
            chk("reset_outputs", int'(outs), 0);
            chk("reset_instr", int'(instr_o), 32'h0000_0013);
            clear_acc();
        end else begin
            m_cyc++;
            m_fmt |= fmt_v;
            if ($countones(fmt_v) > 1) m_inv++;
            if (state_o < 3'd2 && fmt_v != 6'b0) m_inv++;
            if (DR_EN_o && DWR_EN_o) m_inv++;
            if ((state_o == 3'd0) != imem_req_o) m_inv++;
            m_rwe += int'(reg_we_o);
            m_ill += int'(illegal_o);
            m_dr  += int'(DR_EN_o);
            m_dwr += int'(DWR_EN_o);
            if (state_o == 3'd4) m_wb = 1'b1;
            if (pc_we_o) begin
                if (q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_pc_we: got 1 required 0 (t=%0t)", $time);
                end else begin
                    e = q.pop_front();
                    chk("fmt_enables", int'(m_fmt), int'(e.fmt));
                    chk("reg_we_count", m_rwe, e.rwe);
                    chk("pc_sel", int'(pc_sel_o), int'(e.sel));
                    chk("illegal_count", m_ill, e.ill);
                    chk("dr_cycles", m_dr, e.dr);
                    chk("dwr_cycles", m_dwr, e.dwr);
                    chk("latency", m_cyc, e.cyc);
                    chk("wb_visited", int'(m_wb), int'(e.wb));
                    chk("retire_state", int'(state_o), int'(e.end_st));
                    chk("invariants", m_inv, 0);
                end
                clear_acc();
            end
        end
    end

    task automatic fetch(input logic [31:0] ins, input int fd, input logic noise);
        for (int i = 0; i < fd; i++) begin
            imem_valid_i = 1'b0;
            dmem_ack_i   = noise;
            @(posedge clk_i); #1;
        end
        imem_valid_i = 1'b1;
        imem_rdata_i = ins;
        dmem_ack_i   = noise;
        @(posedge clk_i); #1;
        imem_valid_i = 1'b0;
        dmem_ack_i   = 1'b0;
    endtask

    task automatic finish_instr(input int md, input logic tk, input logic noise);
        int m = 0;
        int n = 0;
        while (state_o != 3'd0) begin
            if (n == 40) begin
                n_cmp++;
                n_bad++;
                $display("FAIL retire_timeout: got state %0d required 0", state_o);
                break;
            end
            if (state_o == 3'd3) begin
                dmem_ack_i = (m == md);
                m++;
            end else begin
                dmem_ack_i = noise;
            end
            branch_taken_i = (state_o == 3'd2) ? tk : (noise & ~tk);
            imem_valid_i   = noise;
            imem_rdata_i   = noise ? 32'h0000_007F : 32'h0;
            @(posedge clk_i); #1;
            n++;
        end
        dmem_ack_i     = 1'b0;
        branch_taken_i = 1'b0;
        imem_valid_i   = 1'b0;
        imem_rdata_i   = 32'h0;
    endtask

    task automatic run(input logic [31:0] ins, input int fd, input int md,
                       input logic tk, input logic noise, input exp_t ex);
        q.push_back(ex);
        fetch(ins, fd, noise);
        finish_instr(md, tk, noise);
    endtask

    initial begin
        int n;
        rst_i = 1'b1;
        imem_valid_i = 1'b0;
        imem_rdata_i = 32'h0;
        dmem_ack_i = 1'b0;
        branch_taken_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1 rst_i = 1'b0;

        //  fmt        rwe sel  ill dr dwr cyc wb end
        run(32'h002081B3, 0, 0, 0, 0, '{6'b100000, 1, 2'b00, 0, 0, 0, 4, 1, 3'd4});
        run(32'h002081B3, 0, 0, 0, 0, '{6'b100000, 1, 2'b00, 0, 0, 0, 4, 1, 3'd4});
        run(32'h0080A283, 0, 2, 0, 0, '{6'b010000, 1, 2'b00, 0, 3, 0, 7, 1, 3'd4});
        run(32'h0020A223, 0, 0, 0, 0, '{6'b001000, 0, 2'b00, 0, 0, 1, 4, 0, 3'd3});
        run(32'h00208463, 0, 0, 1, 0, '{6'b000100, 0, 2'b01, 0, 0, 0, 3, 0, 3'd2});
        run(32'h00208463, 0, 0, 0, 1, '{6'b000100, 0, 2'b00, 0, 0, 0, 3, 0, 3'd2});
        run(32'h0000006F, 0, 0, 0, 0, '{6'b000001, 0, 2'b01, 0, 0, 0, 4, 1, 3'd4});
        run(32'h000080E7, 0, 0, 0, 1, '{6'b010000, 1, 2'b10, 0, 0, 0, 4, 1, 3'd4});
        run(32'h0000007F, 0, 0, 0, 0, '{6'b000000, 0, 2'b00, 1, 0, 0, 2, 0, 3'd1});
        run(32'h000002B7, 1, 0, 0, 1, '{6'b000010, 1, 2'b00, 0, 0, 0, 5, 1, 3'd4});
        run(32'h0020A223, 0, 2, 0, 1, '{6'b001000, 0, 2'b00, 0, 0, 3, 6, 0, 3'd3});

        // Abort a load while it waits in MEM; the ack arrives too late.
        fetch(32'h0080A283, 0, 1'b0);
        n = 0;
        while (state_o != 3'd3 && n < 10) begin
            @(posedge clk_i); #1;
            n++;
        end
        chk("reached_mem", int'(state_o), 3);
        rst_i = 1'b1;
        repeat (2) begin
            @(posedge clk_i); #1;
            dmem_ack_i = 1'b1;
        end
        rst_i = 1'b0;
        run(32'h002081B3, 2, 0, 0, 1, '{6'b100000, 1, 2'b00, 0, 0, 0, 6, 1, 3'd4});

        repeat (2) @(posedge clk_i);
        chk("queue_drained", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
